// File: rtl/count_pwm_gen_pkg.sv
// -----------------------------------------------------------------------------
// count_pwm_pkg
// Shared types and constants for the counter-driven PWM generator and for
// other consumers of the free-running up-counter's count bus.
//   state_t    : generator state (IDLE, ARM, RUN, STOP_PEND), 2-bit encoding
//   CW_DEF     : default counter / duty width
//   COUNT_MAX  : terminal count of a CW_DEF-bit counter
//   count_max(): terminal count for an arbitrary width
// -----------------------------------------------------------------------------
package count_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    RUN       = 2'd2,
    STOP_PEND = 2'd3
  } state_t;

  localparam int CW_DEF = 4;

  function automatic int count_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  localparam int COUNT_MAX = count_max(CW_DEF);

endpackage

// File: rtl/count_pwm_gen_if.sv
// -----------------------------------------------------------------------------
// count_pwm_gen_if
// Duty-programming handshake between a duty source and count_pwm_gen.
//   duty_in    : new duty value (high counts per period)
//   duty_valid : duty_in is valid
//   duty_ready : generator's shadow register is empty
// A transfer happens on a clock edge where duty_valid && duty_ready.
// Modports: master (duty source), slave (generator).
// -----------------------------------------------------------------------------
interface count_pwm_gen_if
  import count_pwm_pkg::*;
#(
  parameter int CW = CW_DEF
);

  logic [CW-1:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/count_pwm_gen_seq_monitor.sv
// -----------------------------------------------------------------------------
// count_seq_monitor
// Watches a free-running up-counter's count bus, detects period boundaries and
// flags illegal count sequences. Usable by any consumer of the counter.
//   clk, rst  : clock, asynchronous active-high reset
//   count     : counter value
//   boundary  : combinational; count has just arrived at 0 from a non-zero value
//   seq_err   : sticky; set one cycle after any transition other than hold or
//               +1 (mod 2^CW); cleared only by rst
// A 0 reached from a value other than the terminal count is an upstream reset:
// it is both an error and a boundary.
// -----------------------------------------------------------------------------
module count_seq_monitor
  import count_pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  output logic          boundary,
  output logic          seq_err
);

  logic [CW-1:0] count_q;
  logic          legal;

  // Incrementing in CW bits makes the terminal-count-to-zero wrap legal.
  assign legal    = (count == count_q) || (count == count_q + CW'(1));
  assign boundary = (count == '0) && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      seq_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, regardless of statement order.
      count_q <= count;
      if (!legal) seq_err <= 1'b1;
    end
  end

endmodule

// File: rtl/count_pwm_gen.sv
// -----------------------------------------------------------------------------
// count_pwm_gen
// Period-aligned PWM generator driven by an upstream free-running up-counter.
// Duty is programmed through a valid/ready handshake into a shadow register and
// committed only at period boundaries, so the waveform never glitches.
//   clk, rst      : clock, asynchronous active-high reset
//   count         : upstream counter value
//   en            : run request (level)
//   dif           : duty handshake (count_pwm_gen_if.slave)
//   pwm_out       : registered PWM, high while count < active duty (1 cycle late)
//   period_start  : one-cycle pulse at each boundary while the waveform runs
//   active        : state != IDLE
//   seq_err       : sticky count-sequence error
//   pwm_out_n     : complementary output, only with PWM_DEADTIME_EN
// Build option PWM_DEADTIME_EN: adds pwm_out_n and DEAD_CYC cycles of dead time
// ahead of every rising edge on either output (DEAD_CYC >= 1).
// -----------------------------------------------------------------------------
module count_pwm_gen
  import count_pwm_pkg::*;
#(
  parameter int CW = CW_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int DEAD_CYC = 1
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        count,
  input  logic                 en,
  count_pwm_gen_if.slave       dif,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 active,
  output logic                 seq_err
`ifdef PWM_DEADTIME_EN
  , output logic               pwm_out_n
`endif
);

  state_t        state;
  logic          boundary;
  logic          pwm_q;
  logic          pwm_calc;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] shadow;
  logic [CW-1:0] duty_eff;
  logic          duty_ready_q;
  logic          xfer;
  logic          direct;

  count_seq_monitor #(.CW(CW)) u_seq_monitor (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .boundary (boundary),
    .seq_err  (seq_err)
  );

  assign dif.duty_ready = duty_ready_q;

  // duty_eff is the duty that applies to the current count: a boundary commit
  // takes effect on count 0 of the new period, not one period later.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves a variable
    // unassigned, which would infer a latch.
    duty_eff = duty_act;
    xfer     = dif.duty_valid && duty_ready_q;
    // In IDLE, or on a boundary, a transfer bypasses the shadow.
    direct   = xfer && ((state == IDLE) || boundary);
    if (direct) begin
      duty_eff = dif.duty_in;
    end else if (boundary && !duty_ready_q) begin
      duty_eff = shadow;
    end
  end

  assign pwm_calc = (count < duty_eff);

  // Shadow/active duty. duty_ready_q doubles as the "shadow empty" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act     <= '0;
      shadow       <= '0;
      duty_ready_q <= 1'b1;
    end else begin
      duty_act <= duty_eff;
      if (xfer && !direct) begin
        shadow       <= dif.duty_in;
        duty_ready_q <= 1'b0;
      end else if (boundary) begin
        duty_ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pwm_q        <= 1'b0;
      period_start <= 1'b0;
      active       <= 1'b0;
    end else begin
      period_start <= 1'b0;
      case (state)
        IDLE: begin
          pwm_q <= 1'b0;
          if (en) begin
            state  <= ARM;
            active <= 1'b1;
          end
        end
        ARM: begin
          if (boundary && en) begin
            state        <= RUN;
            pwm_q        <= pwm_calc;
            period_start <= 1'b1;
          end else begin
            pwm_q <= 1'b0;
            if (!en) begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
        end
        RUN: begin
          pwm_q        <= pwm_calc;
          period_start <= boundary;
          if (!en) state <= STOP_PEND;
        end
        STOP_PEND: begin
          if (en) begin
            state        <= RUN;
            pwm_q        <= pwm_calc;
            period_start <= boundary;
          end else if (boundary) begin
            state  <= IDLE;
            active <= 1'b0;
            pwm_q  <= 1'b0;
          end else begin
            pwm_q <= pwm_calc;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
          pwm_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWM_DEADTIME_EN
  // Both outputs are blanked for DEAD_CYC cycles after every edge of pwm_q:
  // the edge cycle itself plus DEAD_CYC-1 counted down by dt_cnt.
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  logic          pwm_d;
  logic [DW-1:0] dt_cnt;
  logic          blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_d  <= 1'b0;
      dt_cnt <= '0;
    end else begin
      pwm_d <= pwm_q;
      if (pwm_q != pwm_d) begin
        dt_cnt <= DW'(DEAD_CYC - 1);
      end else if (dt_cnt != '0) begin
        dt_cnt <= dt_cnt - DW'(1);
      end
    end
  end

  assign blank     = (pwm_q != pwm_d) || (dt_cnt != '0);
  assign pwm_out   = pwm_q && !blank;
  assign pwm_out_n = !pwm_q && !blank && ((state == RUN) || (state == STOP_PEND));
`else
  assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_count_pwm_gen
// Self-checking bench for count_pwm_gen: directed scenarios followed by random
// enable/duty/counter traffic, all compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_count_pwm_gen;
  import count_pwm_pkg::*;

  localparam int CW = 4;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_STOP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cnt;
  logic          en;
  logic          pwm_out;
  logic          period_start;
  logic          active;
  logic          seq_err;
`ifdef PWM_DEADTIME_EN
  logic          pwm_out_n;
`endif

  count_pwm_gen_if #(.CW(CW)) dif ();

  count_pwm_gen #(.CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (cnt),
    .en           (en),
    .dif          (dif),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .active       (active),
    .seq_err      (seq_err)
`ifdef PWM_DEADTIME_EN
    , .pwm_out_n  (pwm_out_n)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: duty bookkeeping and run mode after each clock edge.
  int m_mode;
  int m_duty;
  int m_shadow;
  bit m_full;
  int m_prev;
  bit m_err;
  bit m_pwm;
  bit m_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_duty   = 0;
    m_shadow = 0;
    m_full   = 1'b0;
    m_prev   = 0;
    m_err    = 1'b0;
    m_pwm    = 1'b0;
    m_ps     = 1'b0;
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    int  c;
    int  next_up;
    int  nm;
    bit  bnd;
    bit  xfer;
    bit  gen;
    c       = int'(cnt);
    next_up = (m_prev == COUNT_MAX) ? 0 : m_prev + 1;
    bnd     = (c == 0) && (m_prev != 0);
    xfer    = dif.duty_valid && !m_full;
    if (xfer && (m_mode == M_IDLE || bnd)) begin
      m_duty = int'(dif.duty_in);
    end else if (xfer) begin
      m_shadow = int'(dif.duty_in);
      m_full   = 1'b1;
    end else if (bnd && m_full) begin
      m_duty = m_shadow;
      m_full = 1'b0;
    end
    case (m_mode)
      M_IDLE:  nm = en ? M_ARM : M_IDLE;
      M_ARM:   nm = !en ? M_IDLE : (bnd ? M_RUN : M_ARM);
      M_RUN:   nm = en ? M_RUN : M_STOP;
      default: nm = en ? M_RUN : (bnd ? M_IDLE : M_STOP);
    endcase
    gen   = (nm == M_RUN) || (nm == M_STOP);
    m_pwm = gen && (c < m_duty);
    m_ps  = gen && bnd;
    if (!(c == m_prev || c == next_up)) m_err = 1'b1;
    m_mode = nm;
    m_prev = c;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pwm_out", pwm_out, m_pwm);
    check("period_start", period_start, m_ps);
    check("active", active, m_mode != M_IDLE);
    check("duty_ready", dif.duty_ready, !m_full);
    check("seq_err", seq_err, m_err);
  endtask

  task automatic adv();
    tick();
    cnt = cnt + 4'd1;
  endtask

  task automatic adv_to(input int v);
    for (int k = 0; k < 2 * (COUNT_MAX + 1) && int'(cnt) != v; k++) adv();
  endtask

  task automatic run_sum(input int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (n) begin
      adv();
      hi += int'(pwm_out);
      ps += int'(period_start);
    end
  endtask

  // Asserts reset away from the clock edge, checks that outputs clear at once,
  // and releases it on a falling edge with the upstream counter back at 0.
  task automatic apply_reset();
    rst            = 1'b1;
    cnt            = '0;
    en             = 1'b0;
    dif.duty_valid = 1'b0;
    dif.duty_in    = '0;
    #1;
    check("rst_pwm_out", pwm_out, 1'b0);
    check("rst_period_start", period_start, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_duty_ready", dif.duty_ready, 1'b1);
    check("rst_seq_err", seq_err, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int ps;
    int h2;
    int p2;
    rst = 1'b1;
    cnt = '0;
    en  = 1'b0;
    dif.duty_valid = 1'b0;
    dif.duty_in    = '0;

    // 1: duty 5 loaded in IDLE, arm, run from the 15->0 wrap.
    apply_reset();
    dif.duty_in = 4'd5; dif.duty_valid = 1'b1;
    adv();
    dif.duty_valid = 1'b0;
    en = 1'b1;
    adv_to(0);
    check("t1_armed_low", pwm_out, 1'b0);
    run_sum(16, hi, ps);
    check("t1_high_cycles", hi, 5);
    check("t1_period_starts", ps, 1);
    run_sum(16, hi, ps);
    check("t1_high_cycles_2", hi, 5);

    // 2: duty 12 sent at count 7 waits in the shadow until the boundary.
    adv_to(7);
    dif.duty_in = 4'd12; dif.duty_valid = 1'b1;
    adv();
    dif.duty_valid = 1'b0;
    check("t2_ready_low", dif.duty_ready, 1'b0);
    run_sum(8, hi, ps);
    check("t2_old_duty_tail", hi, 0);
    run_sum(16, hi, ps);
    check("t2_new_duty", hi, 12);
    check("t2_ready_back", dif.duty_ready, 1'b1);

    // 3: drop en at count 3; the period completes, then IDLE without a pulse.
    adv_to(3);
    en = 1'b0;
    run_sum(13, hi, ps);
    check("t3_tail_high", hi, 9);
    check("t3_still_active", active, 1'b1);
    adv();
    check("t3_idle_pwm", pwm_out, 1'b0);
    check("t3_idle_active", active, 1'b0);
    check("t3_no_pulse", period_start, 1'b0);

    // 4: duty 0 for a full period, then duty 15 transferred on the boundary.
    dif.duty_in = 4'd0; dif.duty_valid = 1'b1;
    adv();
    dif.duty_valid = 1'b0;
    en = 1'b1;
    adv_to(0);
    adv_to(0);
    run_sum(16, hi, ps);
    check("t4_duty0_high", hi, 0);
    check("t4_duty0_pulse", ps, 1);
    dif.duty_in = 4'd15; dif.duty_valid = 1'b1;
    adv();
    hi = int'(pwm_out);
    dif.duty_valid = 1'b0;
    check("t4_bypass_ready", dif.duty_ready, 1'b1);
    run_sum(15, h2, p2);
    check("t4_duty15_high", hi + h2, 15);

    // 5: a held count is legal; an upstream reset 9->0 is an error and a boundary.
    adv_to(5);
    tick();
    tick();
    adv();
    check("t5_hold_no_err", seq_err, 1'b0);
    dif.duty_in = 4'd9; dif.duty_valid = 1'b1;
    adv();
    dif.duty_valid = 1'b0;
    adv_to(9);
    adv();
    cnt = '0;
    adv();
    hi = int'(pwm_out);
    check("t5_err_set", seq_err, 1'b1);
    check("t5_jump_pulse", period_start, 1'b1);
    run_sum(15, h2, p2);
    check("t5_committed_duty", hi + h2, 9);
    check("t5_err_sticky", seq_err, 1'b1);

    // 6: reset in RUN at count 2 with duty 3 pending; it must never apply.
    adv();
    dif.duty_in = 4'd3; dif.duty_valid = 1'b1;
    adv();
    dif.duty_valid = 1'b0;
    check("t6_shadow_full", dif.duty_ready, 1'b0);
    adv();
    apply_reset();
    en = 1'b1;
    adv();
    adv_to(0);
    run_sum(16, hi, ps);
    check("t6_shadow_discarded", hi, 0);
    check("t6_pulse", ps, 1);

    // Random traffic: enable toggles, duty offers, holds, jumps, resets.
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      int r;
      if ($urandom_range(0, 99) < 3) en = ~en;
      dif.duty_valid = ($urandom_range(0, 3) == 0);
      dif.duty_in    = 4'($urandom_range(0, COUNT_MAX));
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        apply_reset();
      end else if (r < 15) begin
        tick();
      end else if (r < 18) begin
        cnt = 4'($urandom_range(0, COUNT_MAX));
        adv();
      end else begin
        adv();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
- Downstream consumer of the free-running 4-bit up counter's `count` bus.
- Turns the counter value into a period-aligned PWM waveform whose duty is programmable through a valid/ready handshake.
- Duty changes are shadowed and committed only at period boundaries, so the output never glitches.
- Also flags count-sequence anomalies, such as the upstream counter being reset mid-period or skipping values.

Parameters:
- CW, 4, width of the `count` input and of the duty value.
- DEAD_CYC, 1, dead-time cycles inserted on the complementary output; used only with PWM_DEADTIME_EN.

Ports:
- clk  in  1  clock, same domain as the upstream counter.
- rst  in  1  asynchronous, active-high reset.
- count  in  CW  counter value from the upstream up-counter.
- en  in  1  run request, level-sensitive.
- duty_in  in  CW  new duty value (number of high counts per period).
- duty_valid  in  1  `duty_in` is valid.
- duty_ready  out  1  shadow register empty; can accept a duty value.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-cycle pulse at each period boundary while in RUN.
- active  out  1  high whenever state != IDLE.
- seq_err  out  1  sticky count-sequence error flag; cleared only by rst.

Behaviour:
- Reset values: state=IDLE, `pwm_out`=0, `period_start`=0, `active`=0, `seq_err`=0, `duty_ready`=1, active duty=0, shadow empty, `count_q`=0.

Boundary and sequence checking:
- `count_q` registers `count` every cycle.
- boundary = (`count`==0) && (`count_q`!=0).
- A held value (`count`==`count_q`) is legal.
- Any other transition except `count`==`count_q`+1 (mod 2^CW) sets `seq_err`. A 0 reached from a non-MAX value counts as an upstream reset: it still sets `seq_err` but is treated as a boundary.

Handshake:
- A transfer occurs when `duty_valid` && `duty_ready`. It loads the shadow register and clears `duty_ready` the next cycle.
- At a boundary with the shadow full, shadow moves to active duty and `duty_ready` returns to 1 the next cycle.
- If a boundary and a transfer occur in the same cycle, the transferred value is committed immediately, bypassing the shadow, and `duty_ready` stays 1.
- In IDLE, a transfer commits directly to active duty.

State machine:
- IDLE: `pwm_out`=0. `en`=1 -> ARM.
- ARM: `pwm_out`=0, waiting for a boundary. On boundary -> RUN. `en`=0 -> IDLE.
- RUN: `pwm_out` registered = (`count` < active duty). That is one cycle of latency from `count`. `period_start` pulses on each boundary. `en`=0 -> STOP_PEND.
- STOP_PEND: keeps generating the waveform. On boundary -> IDLE with `pwm_out` forced 0, no `period_start`. `en`=1 again -> RUN with no gap.

Duty limits:
- duty=0 gives a constant low output.
- duty=2^CW-1 gives high for 2^CW-1 of 2^CW counts; 100% duty is not representable.

Reset mid-operation:
- Asynchronous return to all reset values, regardless of state. The shadow is discarded.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- With the macro:
  - Adds output port `pwm_out_n` (1 bit), the complement of `pwm_out`.
  - On every `pwm_out` edge, the rising output is delayed by DEAD_CYC cycles, so both outputs are low during dead time. This uses a small down-counter.
  - If a pulse is shorter than DEAD_CYC, that output stays low for that pulse.
  - `pwm_out_n`=0 in IDLE and ARM.
- Without the macro: port `pwm_out_n` and the dead-time logic are absent, and `pwm_out` timing is exactly as described in Behaviour.

Decomposition:
- Package `count_pwm_pkg`:
  - state enum (IDLE, ARM, RUN, STOP_PEND), 2-bit encoding.
  - CW default constant.
  - `COUNT_MAX` localparam expression.
- Sub-module `count_seq_monitor`:
  - Holds the `count_q` register, boundary detect and `seq_err` logic.
  - Outputs `boundary` and `seq_err`.
  - Reusable by other counter consumers.

Test Plan:
1. Reset, load duty=5 in IDLE, `en`=1, counter free-running -> ARM until `count` 15->0. Then `pwm_out` high for exactly 5 cycles per 16 (one cycle after `count`=0..4), with `period_start` pulsing every 16 cycles.
2. In RUN with duty=5, send duty=12 at `count`=7 -> `duty_ready`=0 until the next boundary. The current period keeps 5 high cycles; the next period has 12. `duty_ready`=1 on the following cycle.
3. Drop `en` at `count`=3 -> state goes to STOP_PEND and the period completes normally. `pwm_out`=0, `active`=0 after the wrap, with no `period_start` on that wrap.
4. Duty=0 then duty=15 -> output constant low for a full period, then 15 of 16 cycles high. Duty transfer in the same cycle as the boundary commits immediately.
5. Upstream counter reset from 9 to 0 mid-period -> `seq_err`=1 and stays set. The event is treated as a boundary and the pending duty is committed. A held `count` (same value for 2 cycles) does not set `seq_err`.
6. Assert rst in RUN at `count`=2 with the shadow full -> all outputs at reset values immediately. After release, the old shadow duty is never applied. With PWM_DEADTIME_EN and DEAD_CYC=1, check one low-low cycle on each edge.
